// File: rtl/pciei_slice_pkg.sv
// Shared slice package: link FSM encoding, credit range limits and the
// credit-counter operation decode used by the credit transmitter.
package pciei_slice_pkg;

  localparam int unsigned CREDITS_MIN = 1;
  localparam int unsigned CREDITS_MAX = 15;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } link_state_t;

  typedef enum logic [1:0] {
    CRD_HOLD = 2'd0,
    CRD_DEC  = 2'd1,
    CRD_INC  = 2'd2,
    CRD_OVF  = 2'd3
  } crd_op_t;

  // A beat and a return in the same cycle cancel; a return with the
  // counter already full is an overflow rather than an increment.
  function automatic crd_op_t crd_op(input logic beat, input logic rtn,
                                     input logic full);
    crd_op_t op;
    op = CRD_HOLD;
    if (beat && !rtn) begin
      op = CRD_DEC;
    end else if (!beat && rtn) begin
      op = full ? CRD_OVF : CRD_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/gp_credit_cnt.sv
// Credit counter: loads the granted credit count, tracks beats and returns,
// saturates at 0 and CREDITS, and flags a sticky overflow on excess returns.
module gp_credit_cnt
  import pciei_slice_pkg::*;
#(
  parameter int unsigned CREDITS   = 4,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n_sync,
  input  logic                 load,
  input  logic                 run,
  input  logic                 beat,
  input  logic                 rtn,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_d;
  logic                 full;
  logic                 empty;
  crd_op_t              op;

  // Next-count decode; returns outside RUN are ignored and never flag overflow.
  always_comb begin
    cnt_d = cnt;
    ovf_d = ovf;
    full  = (cnt == FULL);
    empty = (cnt == '0);
    op    = crd_op(beat & run & ~empty, rtn & run, full);
    if (load) begin
      cnt_d = FULL;
    end else begin
      unique case (op)
        CRD_DEC:  cnt_d = cnt - CNT_WIDTH'(1);
        CRD_INC:  cnt_d = cnt + CNT_WIDTH'(1);
        CRD_OVF:  ovf_d = 1'b1;
        default:  cnt_d = cnt;
      endcase
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: rtl/gp_credit_tx.sv
// Credit-based link transmitter: accepts upstream beats while credits remain,
// forwards each beat onto the link one cycle later without backpressure.
module gp_credit_tx
  import pciei_slice_pkg::*;
#(
  parameter int unsigned PAYLD_WIDTH = 32,
  parameter int unsigned CREDITS     = 4,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n_sync,
  input  logic                   vld_m,
  output logic                   rdy_m,
  input  logic [PAYLD_WIDTH-1:0] payld_m,
  output logic                   vld_s,
  output logic [PAYLD_WIDTH-1:0] payld_s,
  input  logic                   crd_rtn,
  output logic [CNT_WIDTH-1:0]   crd_cnt,
  output logic                   idle,
  output logic                   crd_ovf
);

  generate
    if (CREDITS < CREDITS_MIN || CREDITS > CREDITS_MAX) begin : g_bad_credits
      $error("gp_credit_tx: CREDITS out of legal range");
    end
    if ((64'd1 << CNT_WIDTH) <= 64'(CREDITS)) begin : g_bad_cnt_width
      $error("gp_credit_tx: CNT_WIDTH too narrow for CREDITS");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);

  link_state_t state_q;
  link_state_t state_d;
  logic        load;
  logic        run;
  logic        beat;

  // Link state register.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // INIT lasts one cycle and loads the granted credits on the way to RUN.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
        load    = 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Ready depends only on registered state, never on vld_m or crd_rtn.
  always_comb begin
    run   = (state_q == ST_RUN);
    rdy_m = run && (crd_cnt != '0);
    beat  = vld_m && rdy_m;
    idle  = run && (crd_cnt == FULL);
  end

  // Link output stage: one-cycle pulse per beat, payload held between beats.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      vld_s   <= 1'b0;
      payld_s <= '0;
    end else begin
      vld_s <= beat;
      if (beat) begin
        payld_s <= payld_m;
      end
    end
  end

  gp_credit_cnt #(
    .CREDITS   (CREDITS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_credit_cnt (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .load       (load),
    .run        (run),
    .beat       (beat),
    .rtn        (crd_rtn),
    .cnt        (crd_cnt),
    .ovf        (crd_ovf)
  );

endmodule

// File: tb/tb_gp_credit_tx.sv
// Self-checking bench for gp_credit_tx: directed link scenarios followed by
// randomized traffic against a credit-pool reference model.
module tb_gp_credit_tx;

  localparam int unsigned W  = 32;
  localparam int unsigned CR = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n_sync;
  logic          vld_m;
  logic          rdy_m;
  logic [W-1:0]  payld_m;
  logic          vld_s;
  logic [W-1:0]  payld_s;
  logic          crd_rtn;
  logic [CW-1:0] crd_cnt;
  logic          idle;
  logic          crd_ovf;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a pool of credits plus a queue of accepted payloads.
  int           m_credits;
  bit           m_run;
  bit           m_ovf;
  bit           m_vld;
  bit           m_beat;
  logic [W-1:0] m_pay;
  logic [W-1:0] sent_q[$];

  int           pulses;
  logic [2:0]   rtn_pipe;

  always #5 clk = ~clk;

  gp_credit_tx #(
    .PAYLD_WIDTH (W),
    .CREDITS     (CR),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .vld_m      (vld_m),
    .rdy_m      (rdy_m),
    .payld_m    (payld_m),
    .vld_s      (vld_s),
    .payld_s    (payld_s),
    .crd_rtn    (crd_rtn),
    .crd_cnt    (crd_cnt),
    .idle       (idle),
    .crd_ovf    (crd_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_credits = 0;
    m_run     = 1'b0;
    m_ovf     = 1'b0;
    m_vld     = 1'b0;
    m_beat    = 1'b0;
    m_pay     = '0;
    sent_q.delete();
  endtask

  task automatic check_outputs();
    check_eq("rdy_m",   rdy_m,   (m_run && m_credits > 0));
    check_eq("vld_s",   vld_s,   m_vld);
    check_eq("payld_s", payld_s, m_pay);
    check_eq("crd_cnt", crd_cnt, m_credits);
    check_eq("crd_ovf", crd_ovf, m_ovf);
    check_eq("idle",    idle,    (m_run && m_credits == CR));
    check_eq("cnt_range", (crd_cnt <= CR), 1'b1);
    if (vld_s === 1'b1) begin
      if (sent_q.size() > 0) check_eq("order", payld_s, sent_q.pop_front());
      else check_eq("order_underrun", sent_q.size(), 1);
    end
  endtask

  // One clock: advance the model on the inputs present at the edge, then check.
  task automatic step();
    @(posedge clk);
    m_beat = m_run && (m_credits > 0) && (vld_m === 1'b1);
    if (!m_run) begin
      m_run     = 1'b1;
      m_credits = CR;
    end else if (m_beat && !crd_rtn) begin
      m_credits--;
    end else if (!m_beat && crd_rtn) begin
      if (m_credits == CR) m_ovf = 1'b1;
      else m_credits++;
    end
    m_vld = m_beat;
    if (m_beat) begin
      m_pay = payld_m;
      sent_q.push_back(payld_m);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n_sync = 1'b0;
    vld_m      = 1'b0;
    crd_rtn    = 1'b0;
    payld_m    = '0;
    rtn_pipe   = '0;
    model_reset();

    // Reset state, before and across clock edges.
    #3;
    check_outputs();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs();
    end

    // Fill from reset: INIT for one cycle, then 4 beats with payloads 1..4.
    rst_n_sync = 1'b1;
    vld_m      = 1'b1;
    payld_m    = 32'h1;
    check_eq("rdy_init", rdy_m, 1'b0);
    step();
    check_eq("rdy_cycle1", rdy_m, 1'b1);
    pulses = 0;
    repeat (7) begin
      step();
      if (vld_s === 1'b1) pulses++;
      if (m_beat) payld_m = payld_m + 1;
    end
    check_eq("fill_pulses", pulses, 4);
    check_eq("fill_rdy", rdy_m, 1'b0);
    check_eq("fill_cnt", crd_cnt, 0);

    // Single credit return at zero allows exactly one more beat.
    crd_rtn = 1'b1;
    step();
    crd_rtn = 1'b0;
    check_eq("one_rtn_cnt", crd_cnt, 1);
    pulses = 0;
    repeat (3) begin
      step();
      if (vld_s === 1'b1) pulses++;
      if (m_beat) payld_m = payld_m + 1;
    end
    check_eq("one_rtn_pulses", pulses, 1);
    check_eq("one_rtn_cnt0", crd_cnt, 0);

    // Steady state at 2 credits: beat and return every cycle, no bubbles.
    vld_m   = 1'b0;
    crd_rtn = 1'b1;
    repeat (2) step();
    check_eq("steady_pre", crd_cnt, 2);
    vld_m  = 1'b1;
    pulses = 0;
    repeat (20) begin
      payld_m = $urandom;
      step();
      if (vld_s === 1'b1) pulses++;
      check_eq("steady_cnt", crd_cnt, 2);
    end
    check_eq("steady_pulses", pulses, 20);

    // Drain to full, then an extra return sets the sticky overflow.
    vld_m = 1'b0;
    repeat (2) step();
    check_eq("drained_idle", idle, 1'b1);
    step();
    crd_rtn = 1'b0;
    check_eq("ovf_set", crd_ovf, 1'b1);
    repeat (3) begin
      step();
      check_eq("ovf_sticky", crd_ovf, 1'b1);
      check_eq("ovf_cnt", crd_cnt, CR);
    end

    // Reset mid-stream with one credit left.
    vld_m = 1'b1;
    repeat (3) begin
      payld_m = $urandom;
      step();
    end
    check_eq("pre_rst_cnt", crd_cnt, 1);
    #2;
    rst_n_sync = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n_sync = 1'b1;
    crd_rtn    = 1'b1;
    check_eq("post_rst_init_cnt", crd_cnt, 0);
    step();
    crd_rtn = 1'b0;
    check_eq("post_rst_cnt", crd_cnt, CR);
    check_eq("init_rtn_no_ovf", crd_ovf, 1'b0);

    // Random upstream traffic, receiver returns each credit 3 cycles later.
    rtn_pipe = '0;
    repeat (300) begin
      vld_m   = 1'($urandom_range(0, 1));
      payld_m = $urandom;
      step();
      rtn_pipe = {rtn_pipe[1:0], m_beat};
      crd_rtn  = rtn_pipe[2];
    end
    vld_m = 1'b0;
    repeat (5) begin
      step();
      rtn_pipe = {rtn_pipe[1:0], 1'b0};
      crd_rtn  = rtn_pipe[2];
    end
    check_eq("rand_final_cnt", crd_cnt, CR);
    check_eq("rand_final_ovf", crd_ovf, 1'b0);
    check_eq("rand_final_idle", idle, 1'b1);
    check_eq("rand_queue_empty", sent_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
